// File: rtl/if_fetch_aligner_pkg.sv
// Shared widths and the packed InstQueue entry layout for the fetch aligner.
package if_fetch_aligner_pkg;

  localparam int SINGLE_WORD    = 32;
  localparam int EXCCODE        = 5;
  localparam int ALL_CHECKPOINT = 8;
  localparam int FETCH_GROUP    = 4;

  typedef struct packed {
    logic [FETCH_GROUP-1:0]                inst_en;
    logic [2:0]                            inst_num;
    logic [SINGLE_WORD-1:0]                base_pc;
    logic [FETCH_GROUP*SINGLE_WORD-1:0]    inst;
    logic [FETCH_GROUP-1:0]                pred_take;
    logic [FETCH_GROUP*SINGLE_WORD-1:0]    pred_dest;
    logic [FETCH_GROUP*ALL_CHECKPOINT-1:0] pred_info;
    logic                                  has_exc;
    logic [EXCCODE-1:0]                    exc_code;
    logic                                  is_refill;
    logic                                  ds_pending;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_aligner_fetch_group_rotator.sv
// Rotates a 16B fetch block so slot0 holds the instruction at the fetch PC, then trims
// the group at the block end or after the delay slot of the first predicted-taken branch.
module fetch_group_rotator
  import if_fetch_aligner_pkg::*;
(
  input  logic [SINGLE_WORD-1:0]                pc,
  input  logic [FETCH_GROUP*SINGLE_WORD-1:0]    data,
  input  logic [FETCH_GROUP-1:0]                pred_take,
  input  logic [FETCH_GROUP*SINGLE_WORD-1:0]    pred_dest,
  input  logic [FETCH_GROUP*ALL_CHECKPOINT-1:0] pred_info,
  input  logic                                  has_exc,
  input  logic [EXCCODE-1:0]                    exc_code,
  input  logic                                  is_refill,
  output fetch_entry_t                          ent
);

  logic [1:0]             off;
  logic [2:0]             avail;
  logic [2:0]             num;
  logic [2:0]             t;
  logic                   found;
  logic [FETCH_GROUP-1:0] rot_take;

  always_comb begin
    ent      = '0;
    off      = pc[3:2];
    avail    = 3'd4 - {1'b0, off};
    rot_take = '0;
    found    = 1'b0;
    t        = 3'd0;
    for (int s = 0; s < FETCH_GROUP; s++) begin
      if (3'(s) < avail) rot_take[s] = pred_take[2'(off + 2'(s))];
    end
    for (int s = 0; s < FETCH_GROUP; s++) begin
      if (!found && rot_take[s]) begin
        found = 1'b1;
        t     = 3'(s);
      end
    end
    // A taken branch keeps its delay slot; if that slot lies past the block, flag it instead.
    if (has_exc)    num = 3'd1;
    else if (found) num = ((t + 3'd2) < avail) ? (t + 3'd2) : avail;
    else            num = avail;

    ent.inst_num   = num;
    ent.base_pc    = pc;
    ent.has_exc    = has_exc;
    ent.exc_code   = exc_code;
    ent.is_refill  = is_refill;
    ent.ds_pending = !has_exc && found && ((t + 3'd2) > avail);
    for (int s = 0; s < FETCH_GROUP; s++) begin
      if (3'(s) < num) begin
        ent.inst_en[s]                 = 1'b1;
        ent.pred_dest[s*32 +: 32]      = pred_dest[{2'(off + 2'(s)), 5'd0} +: 32];
        ent.pred_info[s*8 +: 8]        = pred_info[{2'(off + 2'(s)), 3'd0} +: 8];
        if (!has_exc) begin
          ent.inst[s*32 +: 32] = data[{2'(off + 2'(s)), 5'd0} +: 32];
          ent.pred_take[s]     = rot_take[s];
        end
      end
    end
  end

endmodule

// File: rtl/if_fetch_aligner.sv
// Last IF stage: packs ICache groups into InstQueue entries through a 2-entry skid FIFO,
// dropping responses whose epoch predates the most recent flush.
module if_fetch_aligner
  import if_fetch_aligner_pkg::*;
#(
  parameter int CKPT_W = 8,
  parameter int EXC_W  = 5,
  parameter int DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SBA_flush_w_i,
  input  logic                  CP0_excOccur_w_i,
  input  logic                  IC_respValid_i,
  input  logic [31:0]           IC_respPC_i,
  input  logic [127:0]          IC_respData_i,
  input  logic                  IC_respEpoch_i,
  input  logic                  IC_hasException_i,
  input  logic [EXC_W-1:0]      IC_ExcCode_i,
  input  logic                  IC_isRefill_i,
  input  logic [3:0]            BP_predTake_i,
  input  logic [127:0]          BP_predDest_i,
  input  logic [4*CKPT_W-1:0]   BP_predInfo_i,
  input  logic                  ID_stopFetch_i,
  output logic                  IF_fetchReady_o,
  output logic                  IF_epoch_o,
  output logic                  IF_valid_o,
  output logic [3:0]            IF_instEnable_o,
  output logic [2:0]            IF_instNum_o,
  output logic [31:0]           IF_instBasePC_o,
  output logic [127:0]          IF_inst_p_o,
  output logic [3:0]            IF_predTake_p_o,
  output logic [127:0]          IF_predDest_p_o,
  output logic [4*CKPT_W-1:0]   IF_predInfo_p_o,
  output logic                  IF_hasException_o,
  output logic [EXC_W-1:0]      IF_ExcCode_o,
  output logic                  IF_isRefill_o,
  output logic                  IF_dsPending_o
);

  logic         flush;
  logic         epoch_q;
  logic [1:0]   count_q;
  logic [1:0]   count_nxt;
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic         ready_q;
  logic         vld_p0;
  logic         pop;
  fetch_entry_t ent_p0;
  fetch_entry_t mem_p1 [2];
  fetch_entry_t head_p1;

  assign flush  = SBA_flush_w_i | CP0_excOccur_w_i;
  assign vld_p0 = IC_respValid_i & ready_q & (IC_respEpoch_i == epoch_q) & !flush;

  fetch_group_rotator u_rotator (
    .pc        (IC_respPC_i),
    .data      (IC_respData_i),
    .pred_take (BP_predTake_i),
    .pred_dest (BP_predDest_i),
    .pred_info (BP_predInfo_i),
    .has_exc   (IC_hasException_i),
    .exc_code  (IC_ExcCode_i),
    .is_refill (IC_isRefill_i),
    .ent       (ent_p0)
  );

  // p0 -> p1: packed group enters the skid FIFO
  always_ff @(posedge clk) begin
    if (vld_p0) mem_p1[wr_ptr_q] <= ent_p0;
  end

  assign pop       = (count_q != 2'd0) & !ID_stopFetch_i;
  assign count_nxt = count_q + 2'(vld_p0) - 2'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      epoch_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else if (flush) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      epoch_q  <= ~epoch_q;
      ready_q  <= 1'b1;
    end else begin
      if (vld_p0) wr_ptr_q <= ~wr_ptr_q;
      if (pop)    rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_nxt;
      ready_q <= count_nxt < 2'(DEPTH);
    end
  end

  // p1 -> InstQueue: head fields are visible only while the write is offered
  assign head_p1 = pop ? mem_p1[rd_ptr_q] : '0;

  assign IF_fetchReady_o   = ready_q;
  assign IF_epoch_o        = epoch_q;
  assign IF_valid_o        = pop;
  assign IF_instEnable_o   = head_p1.inst_en;
  assign IF_instNum_o      = head_p1.inst_num;
  assign IF_instBasePC_o   = head_p1.base_pc;
  assign IF_inst_p_o       = head_p1.inst;
  assign IF_predTake_p_o   = head_p1.pred_take;
  assign IF_predDest_p_o   = head_p1.pred_dest;
  assign IF_predInfo_p_o   = head_p1.pred_info;
  assign IF_hasException_o = head_p1.has_exc;
  assign IF_ExcCode_o      = head_p1.exc_code;
  assign IF_isRefill_o     = head_p1.is_refill;
  assign IF_dsPending_o    = head_p1.ds_pending;

endmodule

// File: tb/tb_if_fetch_aligner.sv
// Directed bench for if_fetch_aligner: packing, backpressure, flush/epoch and reset cases.
module tb_if_fetch_aligner;

  logic         clk = 1'b0;
  logic         rst;
  logic         SBA_flush_w_i, CP0_excOccur_w_i;
  logic         IC_respValid_i;
  logic [31:0]  IC_respPC_i;
  logic [127:0] IC_respData_i;
  logic         IC_respEpoch_i;
  logic         IC_hasException_i;
  logic [4:0]   IC_ExcCode_i;
  logic         IC_isRefill_i;
  logic [3:0]   BP_predTake_i;
  logic [127:0] BP_predDest_i;
  logic [31:0]  BP_predInfo_i;
  logic         ID_stopFetch_i;
  logic         IF_fetchReady_o, IF_epoch_o, IF_valid_o;
  logic [3:0]   IF_instEnable_o;
  logic [2:0]   IF_instNum_o;
  logic [31:0]  IF_instBasePC_o;
  logic [127:0] IF_inst_p_o;
  logic [3:0]   IF_predTake_p_o;
  logic [127:0] IF_predDest_p_o;
  logic [31:0]  IF_predInfo_p_o;
  logic         IF_hasException_o;
  logic [4:0]   IF_ExcCode_o;
  logic         IF_isRefill_o;
  logic         IF_dsPending_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  if_fetch_aligner dut (
    .clk(clk), .rst(rst),
    .SBA_flush_w_i(SBA_flush_w_i), .CP0_excOccur_w_i(CP0_excOccur_w_i),
    .IC_respValid_i(IC_respValid_i), .IC_respPC_i(IC_respPC_i),
    .IC_respData_i(IC_respData_i), .IC_respEpoch_i(IC_respEpoch_i),
    .IC_hasException_i(IC_hasException_i), .IC_ExcCode_i(IC_ExcCode_i),
    .IC_isRefill_i(IC_isRefill_i), .BP_predTake_i(BP_predTake_i),
    .BP_predDest_i(BP_predDest_i), .BP_predInfo_i(BP_predInfo_i),
    .ID_stopFetch_i(ID_stopFetch_i),
    .IF_fetchReady_o(IF_fetchReady_o), .IF_epoch_o(IF_epoch_o),
    .IF_valid_o(IF_valid_o), .IF_instEnable_o(IF_instEnable_o),
    .IF_instNum_o(IF_instNum_o), .IF_instBasePC_o(IF_instBasePC_o),
    .IF_inst_p_o(IF_inst_p_o), .IF_predTake_p_o(IF_predTake_p_o),
    .IF_predDest_p_o(IF_predDest_p_o), .IF_predInfo_p_o(IF_predInfo_p_o),
    .IF_hasException_o(IF_hasException_o), .IF_ExcCode_o(IF_ExcCode_o),
    .IF_isRefill_o(IF_isRefill_o), .IF_dsPending_o(IF_dsPending_o)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic ep, input logic [3:0] take);
    IC_respValid_i = 1'b1;
    IC_respPC_i    = pc;
    IC_respEpoch_i = ep;
    BP_predTake_i  = take;
  endtask

  initial begin
    rst = 1'b1;
    SBA_flush_w_i = 0; CP0_excOccur_w_i = 0; IC_respValid_i = 0; IC_respPC_i = '0;
    IC_respEpoch_i = 0; IC_hasException_i = 0; IC_ExcCode_i = '0; IC_isRefill_i = 0;
    BP_predTake_i = '0; ID_stopFetch_i = 0;
    for (int k = 0; k < 4; k++) begin
      IC_respData_i[k*32 +: 32] = 32'hC0DE0000 + 32'(k);
      BP_predDest_i[k*32 +: 32] = 32'h80000000 + 32'(k * 16);
      BP_predInfo_i[k*8 +: 8]   = 8'h10 + 8'(k);
    end
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("rst_ready", IF_fetchReady_o, 1);
    chk("rst_valid", IF_valid_o, 0);
    chk("rst_epoch", IF_epoch_o, 0);
    chk("rst_enable", IF_instEnable_o, 0);

    // unaligned PC, no taken branch
    offer(32'h1FC00008, 1'b0, 4'b0000);
    cyc();
    IC_respValid_i = 0;
    #1;
    chk("t1_valid", IF_valid_o, 1);
    chk("t1_enable", IF_instEnable_o, 4'b0011);
    chk("t1_num", IF_instNum_o, 2);
    chk("t1_inst", IF_inst_p_o, {64'h0, 32'hC0DE0003, 32'hC0DE0002});
    chk("t1_basepc", IF_instBasePC_o, 32'h1FC00008);
    chk("t1_ds", IF_dsPending_o, 0);
    cyc();
    chk("t1_drained", IF_valid_o, 0);

    // taken branch in slot1 keeps its delay slot
    offer(32'h1FC00000, 1'b0, 4'b0010);
    cyc();
    IC_respValid_i = 0;
    #1;
    chk("t2a_num", IF_instNum_o, 3);
    chk("t2a_enable", IF_instEnable_o, 4'b0111);
    chk("t2a_ds", IF_dsPending_o, 0);
    chk("t2a_take", IF_predTake_p_o, 4'b0010);
    chk("t2a_dest", IF_predDest_p_o, {32'h0, 32'h80000020, 32'h80000010, 32'h80000000});
    chk("t2a_info", IF_predInfo_p_o, {8'h00, 8'h12, 8'h11, 8'h10});
    cyc();
    // taken branch in the last slot: delay slot falls outside the block
    offer(32'h1FC00000, 1'b0, 4'b1000);
    cyc();
    IC_respValid_i = 0;
    #1;
    chk("t2b_num", IF_instNum_o, 4);
    chk("t2b_enable", IF_instEnable_o, 4'b1111);
    chk("t2b_ds", IF_dsPending_o, 1);
    cyc();

    // backpressure: only two groups fit
    ID_stopFetch_i = 1;
    offer(32'h00000100, 1'b0, 4'b0000);
    cyc();
    chk("t3_ready_after1", IF_fetchReady_o, 1);
    offer(32'h00000110, 1'b0, 4'b0000);
    cyc();
    chk("t3_ready_after2", IF_fetchReady_o, 0);
    chk("t3_valid_stalled", IF_valid_o, 0);
    offer(32'h00000120, 1'b0, 4'b0000);
    cyc(); cyc();
    chk("t3_ready_full", IF_fetchReady_o, 0);
    IC_respValid_i = 0;
    ID_stopFetch_i = 0;
    #1;
    chk("t3_valid_g1", IF_valid_o, 1);
    chk("t3_pc_g1", IF_instBasePC_o, 32'h00000100);
    cyc();
    chk("t3_valid_g2", IF_valid_o, 1);
    chk("t3_pc_g2", IF_instBasePC_o, 32'h00000110);
    cyc();
    chk("t3_empty", IF_valid_o, 0);

    // flush with a full FIFO, then epoch filtering
    ID_stopFetch_i = 1;
    offer(32'h00000200, 1'b0, 4'b0000);
    cyc();
    offer(32'h00000210, 1'b0, 4'b0000);
    cyc();
    IC_respValid_i = 0;
    SBA_flush_w_i = 1;
    cyc();
    SBA_flush_w_i = 0;
    ID_stopFetch_i = 0;
    #1;
    chk("t4_valid", IF_valid_o, 0);
    chk("t4_epoch", IF_epoch_o, 1);
    chk("t4_ready", IF_fetchReady_o, 1);
    offer(32'h00000220, 1'b0, 4'b0000);
    cyc();
    IC_respValid_i = 0;
    #1;
    chk("t4_stale_dropped", IF_valid_o, 0);
    offer(32'h00000230, 1'b1, 4'b0000);
    cyc();
    IC_respValid_i = 0;
    #1;
    chk("t4_new_valid", IF_valid_o, 1);
    chk("t4_new_pc", IF_instBasePC_o, 32'h00000230);
    cyc();

    // exception group
    offer(32'h00000300, 1'b1, 4'b1111);
    IC_hasException_i = 1; IC_ExcCode_i = 5'd4; IC_isRefill_i = 1;
    cyc();
    IC_respValid_i = 0; IC_hasException_i = 0; IC_ExcCode_i = '0; IC_isRefill_i = 0;
    #1;
    chk("t5_num", IF_instNum_o, 1);
    chk("t5_enable", IF_instEnable_o, 4'b0001);
    chk("t5_exc", IF_hasException_o, 1);
    chk("t5_code", IF_ExcCode_o, 4);
    chk("t5_refill", IF_isRefill_o, 1);
    chk("t5_inst", IF_inst_p_o, 0);
    chk("t5_take", IF_predTake_p_o, 0);
    cyc();

    // reset with one group buffered
    ID_stopFetch_i = 1;
    offer(32'h00000400, 1'b1, 4'b0000);
    cyc();
    IC_respValid_i = 0;
    rst = 1;
    cyc();
    rst = 0;
    ID_stopFetch_i = 0;
    #1;
    chk("t6_valid", IF_valid_o, 0);
    chk("t6_epoch", IF_epoch_o, 0);
    chk("t6_ready", IF_fetchReady_o, 1);
    chk("t6_basepc", IF_instBasePC_o, 0);

    // flush coinciding with an otherwise acceptable response
    offer(32'h00000500, 1'b0, 4'b0000);
    CP0_excOccur_w_i = 1;
    #1;
    chk("t7_valid_same", IF_valid_o, 0);
    cyc();
    IC_respValid_i = 0;
    CP0_excOccur_w_i = 0;
    #1;
    chk("t7_valid_next", IF_valid_o, 0);
    chk("t7_epoch", IF_epoch_o, 1);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
